// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : alu_defs                                                         |
// | Shared ALU op codes, legality check and arbiter state encodings.           |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_defs;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : alu_arbiter_if                                                 |
// | Requester handshakes, result return and ALU drive/capture signals.         |
// | Rev       : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  logic             Req0, Req1;
  logic [OPW-1:0]   Op0, Op1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic             Flip0, Flip1;
  logic             Gnt0, Gnt1;
  logic             Done0, Done1;
  logic [WIDTH-1:0] Result;
  logic             ZeroOut;
  logic             Err;
  logic             Busy;
  logic [OPW-1:0]   ALUct1;
  logic [WIDTH-1:0] AluA, AluB;
  logic             AluFlip;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;

  // master = requesters plus the external ALU; slave = the arbiter
  modport master (
    output Req0, Req1, Op0, Op1, A0, B0, A1, B1, Flip0, Flip1, ALUOut, Zero,
    input  Gnt0, Gnt1, Done0, Done1, Result, ZeroOut, Err, Busy,
           ALUct1, AluA, AluB, AluFlip
  );

  modport slave (
    input  Req0, Req1, Op0, Op1, A0, B0, A1, B1, Flip0, Flip1, ALUOut, Zero,
    output Gnt0, Gnt1, Done0, Done1, Result, ZeroOut, Err, Busy,
           ALUct1, AluA, AluB, AluFlip
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arb2                                                           |
// | Two-way round-robin picker; on a tie the port not served last wins.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       next_last
);
  logic [1:0] w_eff;

  assign w_eff = req & ~mask;

  always_comb begin
    gnt = w_eff;
    if (&w_eff) begin
      gnt = last ? 2'b01 : 2'b10;
    end
    next_last = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last);
  end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_arbiter                                                       |
// | Shares one ALU between two req/done requesters (IDLE -> EXEC -> RESP).     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_arbiter
  import alu_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic          CLK,
  input  logic          Reset_n,
  alu_arbiter_if.slave  bus
);

  state_t           r_state, w_next_state;
  logic             r_win;
  logic             r_last;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_flip;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic [1:0]       w_req, w_mask, w_gnt;
  logic             w_next_last;
  logic             w_exec, w_resp, w_legal;

  assign w_exec  = (r_state == ST_EXEC);
  assign w_resp  = (r_state == ST_RESP);
  assign w_legal = is_legal_op(r_op);

  // Requests are only looked at in IDLE/RESP; in RESP the port being answered is masked
  assign w_req  = w_exec ? 2'b00 : {bus.Req1, bus.Req0};
  assign w_mask = w_resp ? (r_win ? 2'b10 : 2'b01) : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req       (w_req),
    .mask      (w_mask),
    .last      (r_last),
    .gnt       (w_gnt),
    .next_last (w_next_last)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (|w_gnt) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: w_next_state = (|w_gnt) ? ST_EXEC : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_win    <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_flip   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (|w_gnt) begin
        r_win  <= w_gnt[1];
        r_last <= w_next_last;
        r_op   <= w_gnt[1] ? bus.Op1   : bus.Op0;
        r_a    <= w_gnt[1] ? bus.A1    : bus.A0;
        r_b    <= w_gnt[1] ? bus.B1    : bus.B0;
        r_flip <= w_gnt[1] ? bus.Flip1 : bus.Flip0;
      end
      if (w_exec) begin
        if (w_legal) begin
          r_result <= bus.ALUOut;
          r_zero   <= bus.Zero;
          r_err    <= 1'b0;
        end else begin
          r_result <= '0;
          r_zero   <= 1'b1;
          r_err    <= 1'b1;
        end
      end
    end
  end

  assign bus.Gnt0    = w_exec & ~r_win;
  assign bus.Gnt1    = w_exec &  r_win;
  assign bus.Done0   = w_resp & ~r_win;
  assign bus.Done1   = w_resp &  r_win;
  assign bus.Busy    = (r_state != ST_IDLE);
  assign bus.Result  = r_result;
  assign bus.ZeroOut = r_zero;
  assign bus.Err     = r_err;

  // An illegal op never reaches the ALU
  assign bus.ALUct1  = (w_exec && w_legal) ? r_op   : '0;
  assign bus.AluA    = (w_exec && w_legal) ? r_a    : '0;
  assign bus.AluB    = (w_exec && w_legal) ? r_b    : '0;
  assign bus.AluFlip = (w_exec && w_legal) ? r_flip : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_arbiter                                                    |
// | Directed and random checks of alu_arbiter against a transaction model.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_alu_arbiter;
  import alu_defs::*;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [17:0] alu_v;
  logic [2:0]  optab [8] = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd3, 3'd4, 3'd5};

  always #5 CLK = ~CLK;

  alu_arbiter_if #(.WIDTH(16), .OPW(3)) bus ();

  alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Expected {err, zero, result} of one requested operation
  function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic flip);
    logic [15:0] x, y, r;
    logic err;
    x = flip ? b : a;
    y = flip ? a : b;
    r = 16'h0;
    err = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a + b;
      3'd6: r = x - y;
      3'd7: r = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      default: err = 1'b1;
    endcase
    return {err, (r == 16'h0), r};
  endfunction

  // External ALU stand-in
  always_comb begin
    alu_v = model(bus.ALUct1, bus.AluA, bus.AluB, bus.AluFlip);
    bus.ALUOut = alu_v[17] ? 16'h0 : alu_v[15:0];
    bus.Zero   = alu_v[17] ? 1'b0  : alu_v[16];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic f);
    if (p == 0) begin
      bus.Req0 = r; bus.Op0 = op; bus.A0 = a; bus.B0 = b; bus.Flip0 = f;
    end else begin
      bus.Req1 = r; bus.Op1 = op; bus.A1 = a; bus.B1 = b; bus.Flip1 = f;
    end
  endtask

  task automatic set_req(input int p, input logic r);
    if (p == 0) bus.Req0 = r;
    else        bus.Req1 = r;
  endtask

  // One isolated transaction from IDLE: Gnt at k+1, Done at k+2, back to IDLE
  task automatic single(input int p, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic f, input string tag);
    logic [17:0] e;
    logic        lg;
    e  = model(op, a, b, f);
    lg = is_legal_op(op);
    drive(p, 1'b1, op, a, b, f);
    step();
    check({tag, " gnt"},      (p == 0) ? bus.Gnt0 : bus.Gnt1, 1);
    check({tag, " gnt other"},(p == 0) ? bus.Gnt1 : bus.Gnt0, 0);
    check({tag, " aluct1"},   bus.ALUct1, lg ? op : 3'd0);
    check({tag, " alua"},     bus.AluA,   lg ? a  : 16'd0);
    step();
    set_req(p, 1'b0);
    check({tag, " done"},      (p == 0) ? bus.Done0 : bus.Done1, 1);
    check({tag, " done other"},(p == 0) ? bus.Done1 : bus.Done0, 0);
    check({tag, " result"},    bus.Result,  e[15:0]);
    check({tag, " zero"},      bus.ZeroOut, e[16]);
    check({tag, " err"},       bus.Err,     e[17]);
    check({tag, " aluct1 resp"}, bus.ALUct1, 0);
    step();
    check({tag, " idle"},      bus.Busy, 0);
  endtask

  // Both ports request continuously for n ops each; service must alternate every 2 cycles
  task automatic run_both(input int n, input string tag);
    int left [2];
    logic [2:0]  cop [2];
    logic [15:0] ca [2], cb [2];
    logic        cf [2];
    logic [17:0] e;
    int got, exp_port, last_cyc, cyc, p;
    got = 0; exp_port = 0; last_cyc = -1; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      cop[i] = optab[$urandom_range(0, 7)];
      ca[i] = 16'($urandom); cb[i] = 16'($urandom); cf[i] = 1'($urandom);
      left[i] = n - 1;
      drive(i, 1'b1, cop[i], ca[i], cb[i], cf[i]);
    end
    while (got < 2 * n && cyc < 20 * n + 20) begin
      step();
      cyc++;
      check({tag, " gnt excl"},  32'(bus.Gnt0 & bus.Gnt1), 0);
      check({tag, " done excl"}, 32'(bus.Done0 & bus.Done1), 0);
      if (bus.Done0 || bus.Done1) begin
        p = bus.Done1 ? 1 : 0;
        check({tag, " order"}, p, exp_port);
        exp_port ^= 1;
        if (last_cyc >= 0) check({tag, " spacing"}, cyc - last_cyc, 2);
        last_cyc = cyc;
        e = model(cop[p], ca[p], cb[p], cf[p]);
        check({tag, " result"}, bus.Result,  e[15:0]);
        check({tag, " zero"},   bus.ZeroOut, e[16]);
        check({tag, " err"},    bus.Err,     e[17]);
        got++;
        if (left[p] > 0) begin
          left[p]--;
          cop[p] = optab[$urandom_range(0, 7)];
          ca[p] = 16'($urandom); cb[p] = 16'($urandom); cf[p] = 1'($urandom);
          drive(p, 1'b1, cop[p], ca[p], cb[p], cf[p]);
        end else begin
          set_req(p, 1'b0);
        end
      end
    end
    check({tag, " complete"}, got, 2 * n);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    step();
    step();
    check({tag, " idle"}, bus.Busy, 0);
  endtask

  initial begin
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    step();
    step();
    check("reset busy",   bus.Busy, 0);
    check("reset gnt",    {bus.Gnt0, bus.Gnt1}, 0);
    check("reset done",   {bus.Done0, bus.Done1}, 0);
    check("reset result", bus.Result, 0);
    check("reset flags",  {bus.ZeroOut, bus.Err}, 0);
    check("reset aluct1", bus.ALUct1, 0);
    Reset_n = 1'b1;
    step();

    // ADD wraps to zero
    single(0, OP_ADD, 16'hFF00, 16'h0100, 1'b0, "t2");
    check("t2 result const", bus.Result, 16'h0000);
    check("t2 zero const",   bus.ZeroOut, 1);

    // Signed SLT, plain
    single(1, OP_SLT, 16'hFFFD, 16'h0002, 1'b0, "t5a");
    check("t5a result const", bus.Result, 16'h0001);

    // Reset while in EXEC aborts the transaction
    drive(0, 1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    step();
    check("t1 in exec", bus.Gnt0, 1);
    Reset_n = 1'b0;
    #1;
    check("t1 async busy", bus.Busy, 0);
    step();
    check("t1 busy",   bus.Busy, 0);
    check("t1 done0",  bus.Done0, 0);
    check("t1 aluct1", bus.ALUct1, 0);
    check("t1 result", bus.Result, 0);
    set_req(0, 1'b0);
    Reset_n = 1'b1;
    step();
    check("t1 idle after", bus.Busy, 0);

    // Simultaneous requests right after reset: port 0 first
    drive(0, 1'b1, OP_SUB, 16'd5, 16'd3, 1'b0);
    drive(1, 1'b1, OP_SUB, 16'd5, 16'd3, 1'b1);
    step();
    check("t3 gnt0", {bus.Gnt1, bus.Gnt0}, 2'b01);
    step();
    check("t3 done0",   {bus.Done1, bus.Done0}, 2'b01);
    check("t3 result0", bus.Result, 16'h0002);
    set_req(0, 1'b0);
    step();
    check("t3 gnt1", {bus.Gnt1, bus.Gnt0}, 2'b10);
    step();
    check("t3 done1",   {bus.Done1, bus.Done0}, 2'b10);
    check("t3 result1", bus.Result, 16'hFFFE);
    check("t3 zero1",   bus.ZeroOut, 0);
    set_req(1, 1'b0);
    step();
    check("t3 idle", bus.Busy, 0);

    run_both(3, "t4");
    run_both(8, "rand both");

    single(1, OP_SLT, 16'hFFFD, 16'h0002, 1'b1, "t5b");
    check("t5b result const", bus.Result, 16'h0000);

    single(0, 3'd4, 16'h1234, 16'h5678, 1'b0, "t6");
    check("t6 err const",    bus.Err, 1);
    check("t6 result const", bus.Result, 0);

    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      single($urandom_range(0, 1), optab[$urandom_range(0, 7)], 16'($urandom),
             16'($urandom), 1'($urandom), "rand single");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
